// File: rtl/soft_reset_seq.sv
// soft_reset_seq: reset-entry sequencer that quiesces, gates, resets, releases and ungates one downstream domain.
// Define SOFT_RESET_ABORT_EN to add abort_i, which cancels a sequence while it is still quiescing.
module soft_reset_seq #(
  parameter int QUIESCE_TIMEOUT = 16,
  parameter int PRE_CYCLES      = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int POST_CYCLES     = 4,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic idle_i,
`ifdef SOFT_RESET_ABORT_EN
  input  logic abort_i,
`endif
  output logic quiesce_o,
  output logic gate_clk_o,
  output logic sw_reset_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o
);
  typedef enum logic [2:0] {IDLE, QUIESCE, STOP, ASSERT, CLK_ON, RELEASE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, lim;
  logic last, abort;
`ifdef SOFT_RESET_ABORT_EN
  assign abort = abort_i;
`else
  assign abort = 1'b0;
`endif
  always_comb begin
    lim = state == QUIESCE ? CNT_W'(QUIESCE_TIMEOUT - 1)
        : state == STOP    ? CNT_W'(PRE_CYCLES - 1)
        : state == ASSERT  ? CNT_W'(1)
        : state == CLK_ON  ? CNT_W'(HOLD_CYCLES - 1)
        :                    CNT_W'(POST_CYCLES - 1);
    last = cnt == lim;
    nxt = state == IDLE    ? (req_i ? QUIESCE : IDLE)
        : state == QUIESCE ? (abort ? IDLE : (idle_i || last) ? STOP : QUIESCE)
        : !last            ? state
        : state == STOP    ? ASSERT
        : state == ASSERT  ? CLK_ON
        : state == CLK_ON  ? RELEASE
        :                    IDLE;
  end
  // Outputs are registered from the next state so they never see a combinational input path.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      quiesce_o  <= 1'b0;
      gate_clk_o <= 1'b1;
      sw_reset_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= (nxt != state || state == IDLE) ? '0 : cnt + 1'b1;
      quiesce_o  <= nxt != IDLE;
      gate_clk_o <= nxt == IDLE || nxt == QUIESCE || nxt == CLK_ON;
      sw_reset_o <= nxt == ASSERT || nxt == CLK_ON;
      busy_o     <= nxt != IDLE;
      done_o     <= state == RELEASE && nxt == IDLE;
      timeout_o  <= (state == IDLE && req_i) ? 1'b0
                  : (state == QUIESCE && !abort && !idle_i && last) ? 1'b1
                  : timeout_o;
    end
endmodule

// File: tb/tb_soft_reset_seq.sv
// tb_soft_reset_seq: scoreboard bench; stimulus queues per-cycle expected outputs, a negedge monitor compares.
module tb_soft_reset_seq;
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, idle = 1'b1, abort = 1'b0;
  logic quiesce, gate_clk, sw_reset, busy, done, timeout;
  logic [5:0] exp_q[$];
  string nm_q[$];
  int compared = 0, mismatched = 0;

  soft_reset_seq dut (
    .clk(clk), .reset(reset), .req_i(req), .idle_i(idle),
`ifdef SOFT_RESET_ABORT_EN
    .abort_i(abort),
`endif
    .quiesce_o(quiesce), .gate_clk_o(gate_clk), .sw_reset_o(sw_reset),
    .busy_o(busy), .done_o(done), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // Vector order: {quiesce, gate_clk, sw_reset, busy, done, timeout}
  always @(negedge clk)
    if (exp_q.size() > 0) begin : mon
      logic [5:0] e, a;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      a = {quiesce, gate_clk, sw_reset, busy, done, timeout};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL %s @%0t: got %b expected %b", n, $time, a, e);
      end
    end

  task automatic step(input bit chk, input logic [5:0] e, input string nm);
    @(posedge clk);
    #1;
    if (chk) begin
      exp_q.push_back(e);
      nm_q.push_back(nm);
    end
  endtask

  // Expected outputs in sequence cycle c when QUIESCE spans cycles 1..q.
  function automatic logic [5:0] exp_at(input int c, input int q, input bit t);
    if (c <= q)      return 6'b110100;
    if (c <= q + 4)  return {5'b10010, t};
    if (c <= q + 6)  return {5'b10110, t};
    if (c <= q + 14) return {5'b11110, t};
    if (c <= q + 18) return {5'b10010, t};
    return {5'b01001, t};
  endfunction

  task automatic idle_cycles(input int n, input bit t, input string nm);
    for (int i = 0; i < n; i++) begin
      step(1'b1, {5'b01000, t}, nm);
      req = 1'b0;
      abort = 1'b0;
    end
  endtask

  task automatic run(input string nm, input int q, input int rise, input bit t,
                     input bit noise, input bit tail, input bit chained, input int abort_at);
    if (!chained) begin
      step(1'b0, 6'b0, nm);
      req = 1'b1;
      idle = rise <= 0;
      abort = 1'b0;
    end
    for (int c = 1; c <= q + 19; c++) begin
      step(1'b1, exp_at(c, q, t), $sformatf("%s_c%0d", nm, c));
      req = (noise && (c == 3 || c == 12)) || (tail && c >= q + 15);
      idle = c >= rise;
      abort = c == abort_at;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 6'b010000, "reset");
    reset = 1'b0;
    idle_cycles(2, 1'b0, "post_reset");
    run("basic", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(2, 1'b0, "basic_idle");
    run("timeout", 16, 1000, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(3, 1'b1, "timeout_sticky");
    run("clear", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(1, 1'b0, "clear_idle");
    run("late_idle", 5, 5, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(1, 1'b0, "late_idle_end");
    run("noise_tail", 1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    run("b2b", 1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    idle_cycles(2, 1'b0, "b2b_idle");
    step(1'b0, 6'b0, "arst");
    req = 1'b1;
    idle = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step(1'b1, exp_at(c, 1, 1'b0), $sformatf("arst_c%0d", c));
      req = 1'b0;
    end
    step(1'b1, 6'b010000, "arst_mid");
    #1 reset = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b1, 6'b010000, "arst_hold");
    reset = 1'b0;
    idle_cycles(3, 1'b0, "arst_no_done");
    run("after_rst", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(1, 1'b0, "after_rst_idle");
`ifdef SOFT_RESET_ABORT_EN
    step(1'b0, 6'b0, "abort_q");
    req = 1'b1;
    idle = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step(1'b1, 6'b110100, $sformatf("abort_q_c%0d", c));
      req = 1'b0;
      abort = c == 3;
    end
    idle_cycles(3, 1'b0, "abort_q_idle");
    run("abort_stop", 1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    idle_cycles(1, 1'b0, "abort_stop_idle");
`endif
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
